// File: rtl/vec_mul_seq_if.sv
// vec_mul_seq_if - handshake/data bundle for the sequential vector multiplier.
//
// Signals:
//   in_valid/in_ready    operand handshake (producer -> multiplier)
//   vec1, vec2           packed operand vectors, element i at [(i+1)*WIDTH-1 : i*WIDTH]
//   out_valid/out_ready  result handshake (multiplier -> consumer)
//   result               packed products, product i at [2*(i+1)*WIDTH-1 : 2*i*WIDTH]
//   dot                  sum of all products (zero when the dot feature is not built)
//   busy                 multiplier is working on or holding a result
//
// Modports:
//   master  the side that supplies operands and consumes results
//   slave   the multiplier itself
interface vec_mul_seq_if #(
  parameter int N     = 8,
  parameter int WIDTH = 8
);

  localparam int DOTW = 2*WIDTH + $clog2(N);

  logic                   in_valid;
  logic                   in_ready;
  logic [N*WIDTH-1:0]     vec1;
  logic [N*WIDTH-1:0]     vec2;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH*N-1:0]   result;
  logic [DOTW-1:0]        dot;
  logic                   busy;

  modport master (
    output in_valid, vec1, vec2, out_ready,
    input  in_ready, out_valid, result, dot, busy
  );

  modport slave (
    input  in_valid, vec1, vec2, out_ready,
    output in_ready, out_valid, result, dot, busy
  );

endinterface

// File: rtl/vec_mul_seq.sv
// vec_mul_seq - sequential, lane-parallel element-wise vector multiplier.
//
// Accepts two N-element vectors of WIDTH-bit elements, multiplies them
// element by element using LANES multipliers over N/LANES cycles, and holds
// the full-precision product vector (and optionally the dot product) on a
// valid/ready output until the consumer takes it.
//
// Ports:
//   clk   sole clock, rising edge
//   rst   synchronous active-high reset
//   bus   vec_mul_seq_if.slave: operand handshake, result handshake, busy
//
// Parameters:
//   N      elements per vector
//   WIDTH  bits per operand element
//   LANES  multipliers instantiated (must divide N)
//   SIGNED 0 = unsigned, 1 = two's-complement operands and products
//
// Optional feature macro:
//   VEC_MUL_SEQ_DOT_EN  build the dot-product accumulator; otherwise dot is 0.
module vec_mul_seq #(
  parameter int N      = 8,
  parameter int WIDTH  = 8,
  parameter int LANES  = 2,
  parameter int SIGNED = 0
) (
  input  logic          clk,
  input  logic          rst,
  vec_mul_seq_if.slave  bus
);

  localparam int PW    = 2*WIDTH;
  localparam int DOTW  = 2*WIDTH + $clog2(N);
  localparam int STEPS = N / LANES;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (N % LANES != 0) begin : g_lanes_check
    $error("vec_mul_seq: N must be a multiple of LANES");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [N*WIDTH-1:0] op1_q;
  logic [N*WIDTH-1:0] op2_q;
  logic [SW-1:0]      step_q;
  logic [N*PW-1:0]    result_q;
  logic [PW-1:0]      prod [LANES];
  logic               last_step;

  // Widen an operand to product width so the multiply is done at full
  // 2*WIDTH precision; the low 2*WIDTH bits of the product are then exact
  // for both unsigned and two's-complement interpretation.
  function automatic logic [PW-1:0] ext_op(input logic [WIDTH-1:0] x);
    if (SIGNED != 0) return {{WIDTH{x[WIDTH-1]}}, x};
    else             return {{WIDTH{1'b0}}, x};
  endfunction

  // The operand registers are shifted down by one lane group per RUN cycle,
  // so the lanes always read the lowest LANES elements.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign prod[l] = ext_op(op1_q[l*WIDTH +: WIDTH]) * ext_op(op2_q[l*WIDTH +: WIDTH]);
  end

  assign last_step = (step_q == SW'(STEPS-1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_next = RUN;
      RUN:     if (last_step)    state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the state register only
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.busy      = (state != IDLE);
  end

  // Operand capture, step counter and product write-back. Each RUN step
  // writes only the slots of its own lane group, so slots not yet reached
  // still read zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      op1_q    <= '0;
      op2_q    <= '0;
      step_q   <= '0;
      result_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op1_q    <= bus.vec1;
            op2_q    <= bus.vec2;
            step_q   <= '0;
            result_q <= '0;
          end
        end
        RUN: begin
          for (int e = 0; e < N; e++) begin
            if (step_q == SW'(e / LANES)) result_q[e*PW +: PW] <= prod[e % LANES];
          end
          op1_q  <= op1_q >> (LANES*WIDTH);
          op2_q  <= op2_q >> (LANES*WIDTH);
          step_q <= step_q + SW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;

`ifdef VEC_MUL_SEQ_DOT_EN
  logic [DOTW-1:0] acc_q;
  logic [DOTW-1:0] lane_sum;

  // Extend a product to accumulator width, keeping its sign when signed.
  function automatic logic [DOTW-1:0] ext_prod(input logic [PW-1:0] p);
    if (SIGNED != 0) return {{(DOTW-PW){p[PW-1]}}, p};
    else             return {{(DOTW-PW){1'b0}}, p};
  endfunction

  // Sum of this step's lane products
  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) lane_sum = lane_sum + ext_prod(prod[l]);
  end

  // Dot-product accumulator, cleared on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (state == IDLE && bus.in_valid) begin
      acc_q <= '0;
    end else if (state == RUN) begin
      acc_q <= acc_q + lane_sum;
    end
  end

  assign bus.dot = acc_q;
`else
  assign bus.dot = '0;
`endif

endmodule

// File: tb/tb_vec_mul_seq.sv
// tb_vec_mul_seq - self-checking bench for vec_mul_seq.
//
// Two instances share clock and stimulus: an unsigned LANES=2 build and a
// signed LANES=4 build. Expected products and dot values come from a plain
// integer reference model of element-wise multiplication.
module tb_vec_mul_seq;

  localparam int N     = 8;
  localparam int WIDTH = 8;
  localparam int DOTW  = 2*WIDTH + $clog2(N);

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  vec_mul_seq_if #(.N(N), .WIDTH(WIDTH)) bu ();
  vec_mul_seq_if #(.N(N), .WIDTH(WIDTH)) bs ();

  vec_mul_seq #(.N(N), .WIDTH(WIDTH), .LANES(2), .SIGNED(0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bu.slave)
  );

  vec_mul_seq #(.N(N), .WIDTH(WIDTH), .LANES(4), .SIGNED(1)) u_dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bs.slave)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference products: every element multiplied at plain integer precision
  function automatic logic [2*WIDTH*N-1:0] modelResult(input logic [N*WIDTH-1:0] a,
                                                       input logic [N*WIDTH-1:0] b,
                                                       input bit sgn);
    logic [2*WIDTH*N-1:0] r;
    int x, y;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (sgn) begin
        x = $signed(a[i*WIDTH +: WIDTH]);
        y = $signed(b[i*WIDTH +: WIDTH]);
      end else begin
        x = int'(a[i*WIDTH +: WIDTH]);
        y = int'(b[i*WIDTH +: WIDTH]);
      end
      r[i*2*WIDTH +: 2*WIDTH] = 16'(x * y);
    end
    return r;
  endfunction

  // Reference dot product, or zero when the feature is not built
  function automatic logic [DOTW-1:0] modelDot(input logic [N*WIDTH-1:0] a,
                                               input logic [N*WIDTH-1:0] b,
                                               input bit sgn);
    longint sum;
    int x, y;
    sum = 0;
    for (int i = 0; i < N; i++) begin
      if (sgn) begin
        x = $signed(a[i*WIDTH +: WIDTH]);
        y = $signed(b[i*WIDTH +: WIDTH]);
      end else begin
        x = int'(a[i*WIDTH +: WIDTH]);
        y = int'(b[i*WIDTH +: WIDTH]);
      end
      sum += longint'(x * y);
    end
`ifdef VEC_MUL_SEQ_DOT_EN
    return DOTW'(sum);
`else
    return '0;
`endif
  endfunction

  // Single comparison point: counts every check, reports any mismatch
  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a vector pair onto both instances and let it be accepted
  task automatic applyStimulus(input logic [N*WIDTH-1:0] v1, input logic [N*WIDTH-1:0] v2);
    bu.vec1 = v1; bu.vec2 = v2; bu.in_valid = 1'b1;
    bs.vec1 = v1; bs.vec2 = v2; bs.in_valid = 1'b1;
    checkOutput("u_in_ready_pre", bu.in_ready, 1);
    checkOutput("s_in_ready_pre", bs.in_ready, 1);
    @(negedge clk);
    bu.in_valid = 1'b0;
    bs.in_valid = 1'b0;
  endtask

  // Wait (bounded) for both results, then check latency and contents
  task automatic waitResult(input logic [N*WIDTH-1:0] v1, input logic [N*WIDTH-1:0] v2);
    int lat_u, lat_s;
    lat_u = -1;
    lat_s = -1;
    checkOutput("u_out_valid_early", bu.out_valid, 0);
    checkOutput("s_out_valid_early", bs.out_valid, 0);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (bu.out_valid && lat_u < 0) lat_u = cyc;
      if (bs.out_valid && lat_s < 0) lat_s = cyc;
      if (lat_u >= 0 && lat_s >= 0) break;
    end
    checkOutput("u_latency", lat_u, 4);
    checkOutput("s_latency", lat_s, 2);
    checkOutput("u_result", bu.result, modelResult(v1, v2, 1'b0));
    checkOutput("s_result", bs.result, modelResult(v1, v2, 1'b1));
    checkOutput("u_dot", bu.dot, modelDot(v1, v2, 1'b0));
    checkOutput("s_dot", bs.dot, modelDot(v1, v2, 1'b1));
    checkOutput("u_busy_done", bu.busy, 1);
    checkOutput("u_in_ready_done", bu.in_ready, 0);
  endtask

  // Complete the output handshake on both instances
  task automatic releaseOutput();
    bu.out_ready = 1'b1;
    bs.out_ready = 1'b1;
    @(negedge clk);
    bu.out_ready = 1'b0;
    bs.out_ready = 1'b0;
    checkOutput("u_out_valid_after", bu.out_valid, 0);
    checkOutput("u_in_ready_after", bu.in_ready, 1);
    checkOutput("s_in_ready_after", bs.in_ready, 1);
  endtask

  // Main sequence
  initial begin
    logic [N*WIDTH-1:0] va, vb, vc, vd;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bu.in_valid = 1'b0; bu.out_ready = 1'b0; bu.vec1 = '0; bu.vec2 = '0;
    bs.in_valid = 1'b0; bs.out_ready = 1'b0; bs.vec1 = '0; bs.vec2 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_u_in_ready", bu.in_ready, 1);
    checkOutput("rst_u_out_valid", bu.out_valid, 0);
    checkOutput("rst_u_busy", bu.busy, 0);
    checkOutput("rst_u_result", bu.result, 0);
    checkOutput("rst_u_dot", bu.dot, 0);
    checkOutput("rst_s_in_ready", bs.in_ready, 1);
    checkOutput("rst_s_result", bs.result, 0);
    checkOutput("rst_s_dot", bs.dot, 0);

    // Basic: elements 1..8 times 3
    for (int i = 0; i < N; i++) begin
      va[i*WIDTH +: WIDTH] = WIDTH'(i + 1);
      vb[i*WIDTH +: WIDTH] = 8'd3;
    end
    applyStimulus(va, vb);
    waitResult(va, vb);
    checkOutput("basic_slot0", bu.result[15:0], 3);
    checkOutput("basic_slot7", bu.result[127:112], 24);
`ifdef VEC_MUL_SEQ_DOT_EN
    checkOutput("basic_dot", bu.dot, 108);
`else
    checkOutput("basic_dot", bu.dot, 0);
`endif
    releaseOutput();

    // Max magnitude: all elements 255
    va = {N{8'hFF}};
    applyStimulus(va, va);
    waitResult(va, va);
    for (int i = 0; i < N; i++) checkOutput("max_slot", bu.result[i*16 +: 16], 16'hFE01);
`ifdef VEC_MUL_SEQ_DOT_EN
    checkOutput("max_dot", bu.dot, 520200);
`endif
    releaseOutput();

    // Signed corner: -128*127 and -1*-1
    va = '0; vb = '0;
    va[7:0] = 8'h80; vb[7:0] = 8'h7F;
    va[15:8] = 8'hFF; vb[15:8] = 8'hFF;
    applyStimulus(va, vb);
    waitResult(va, vb);
    checkOutput("signed_slot0", bs.result[15:0], 16'hC080);
    checkOutput("signed_slot1", bs.result[31:16], 16'h0001);
`ifdef VEC_MUL_SEQ_DOT_EN
    checkOutput("signed_dot", bs.dot, 19'h7C081);
`else
    checkOutput("signed_dot", bs.dot, 0);
`endif
    releaseOutput();

    // Backpressure: hold DONE while new operands wait on the input
    va = {$urandom, $urandom};
    vb = {$urandom, $urandom};
    vc = {$urandom, $urandom};
    vd = {$urandom, $urandom};
    applyStimulus(va, vb);
    waitResult(va, vb);
    bu.vec1 = vc; bu.vec2 = vd; bu.in_valid = 1'b1;
    bs.vec1 = vc; bs.vec2 = vd; bs.in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      checkOutput("bp_u_result", bu.result, modelResult(va, vb, 1'b0));
      checkOutput("bp_s_result", bs.result, modelResult(va, vb, 1'b1));
      checkOutput("bp_u_dot", bu.dot, modelDot(va, vb, 1'b0));
      checkOutput("bp_u_in_ready", bu.in_ready, 0);
      checkOutput("bp_u_out_valid", bu.out_valid, 1);
    end
    releaseOutput();
    @(negedge clk);
    bu.in_valid = 1'b0;
    bs.in_valid = 1'b0;
    waitResult(vc, vd);
    releaseOutput();

    // Reset on the second RUN cycle
    va = {$urandom, $urandom};
    vb = {$urandom, $urandom};
    applyStimulus(va, vb);
    checkOutput("mid_u_busy", bu.busy, 1);
    @(negedge clk);
    rst = 1'b1;
    checkOutput("mid_u_out_valid", bu.out_valid, 0);
    checkOutput("mid_s_out_valid", bs.out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid_u_in_ready", bu.in_ready, 1);
    checkOutput("mid_u_busy_clr", bu.busy, 0);
    checkOutput("mid_u_result", bu.result, 0);
    checkOutput("mid_u_dot", bu.dot, 0);
    checkOutput("mid_s_out_valid2", bs.out_valid, 0);
    checkOutput("mid_s_result", bs.result, 0);
    repeat (6) begin
      @(negedge clk);
      checkOutput("mid_u_no_pulse", bu.out_valid, 0);
      checkOutput("mid_s_no_pulse", bs.out_valid, 0);
    end
    vc = {$urandom, $urandom};
    vd = {$urandom, $urandom};
    applyStimulus(vc, vd);
    waitResult(vc, vd);
    releaseOutput();

    // Randomized vectors against the reference model
    for (int k = 0; k < 6; k++) begin
      va = {$urandom, $urandom};
      vb = {$urandom, $urandom};
      applyStimulus(va, vb);
      waitResult(va, vb);
      releaseOutput();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_mul_seq.md
# vec_mul_seq

Sequential, lane-parallel element-wise vector multiplier. It accepts two N-element vectors of WIDTH-bit elements over a valid/ready handshake. It computes the N products with LANES multipliers over N/LANES cycles and presents the full 2·WIDTH-per-element product vector (and, optionally, the dot product) on a valid/ready output. It is the area-scalable replacement for the fully parallel vector multiplier in the uart_task datapath: it sits between the UART frame unpacker and the response packer.

## Interface
- N, 8, number of elements per vector
- WIDTH, 8, bits per input element
- LANES, 2, multipliers instantiated; N % LANES must be 0, otherwise elaboration fails
- SIGNED, 0, 0: unsigned operands/products; 1: two's-complement operands/products
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  vec1/vec2 valid
- in_ready  output  1  block can accept a vector pair
- vec1  input  N*WIDTH  element i at [(i+1)*WIDTH-1 : i*WIDTH]
- vec2  input  N*WIDTH  same packing as vec1
- out_valid  output  1  result (and dot) valid
- out_ready  input  1  consumer accepts result
- result  output  2*WIDTH*N  product i at [2*(i+1)*WIDTH-1 : 2*i*WIDTH]
- dot  output  2*WIDTH+$clog2(N)  sum of all products (see Configuration)
- busy  output  1  high in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE. in_ready = (state==IDLE); out_valid = (state==DONE); busy = (state!=IDLE).
- IDLE: on in_valid && in_ready, register vec1 and vec2, clear the result register and accumulator, set idx=0, and go to RUN.
- RUN: each cycle compute products for elements idx..idx+LANES-1 from the registered operands, write them into their result slots, add their sum to the accumulator, and set idx += LANES. On the cycle idx+LANES == N, perform the final write and go to DONE.
- DONE: result and dot are held stable. On out_ready, go to IDLE. in_valid is ignored in RUN and DONE; no input is lost, because in_ready is low.
- Arithmetic: each product is exactly 2*WIDTH bits, and no overflow is possible. When SIGNED=1, operands are sign-interpreted, and each product is stored as a 2*WIDTH-bit two's-complement value. dot is sign-extended per product when SIGNED=1 and zero-extended when SIGNED=0. dot width is sufficient for N maximum-magnitude products, so no overflow is possible.
- Result slots not yet written during RUN read 0. Consumers only sample them under out_valid.
- Reset at any time, including mid-RUN or in DONE:
  - state=IDLE, idx=0, result=0, dot=0
  - the in-flight operation is discarded, and no out_valid pulse is produced.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, result=0, dot=0.
- Accept at edge T0 (in_valid&&in_ready). out_valid rises after edge T0+N/LANES, i.e. N/LANES cycles of RUN.
- Output handshake completes at the edge where out_valid&&out_ready. in_ready is high from the next cycle.
- Minimum initiation interval: N/LANES+2 cycles (RUN cycles, one DONE cycle with out_ready=1, one IDLE accept cycle).
- out_ready held low: DONE persists indefinitely, with result/dot bit-stable.
- All outputs are registered or decoded from the state register only. There is no combinational path from inputs to outputs.

## Configuration
- VEC_MUL_SEQ_DOT_EN defined: the accumulator is built, and dot carries the sum of products, valid under out_valid with the same latency as result.
- Not defined: the accumulator is not synthesized and dot is tied to 0. result timing and behaviour are identical.

## Test plan
- Reset: rst=1 for 2 cycles, then check in_ready=1, out_valid=0, busy=0, result=0, dot=0.
- Basic, N=8, WIDTH=8, LANES=2, SIGNED=0: vec1 elements 1..8, vec2 all 3. Check out_valid 4 cycles after accept, result slots 3,6,…,24, and dot=108 (macro on) or 0 (macro off).
- Max magnitude, unsigned: all elements 255. Check every slot = 65025 (0xFE01) and dot = 520200 in 19 bits.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, with in_valid=1 and new operands applied. Check result stable, in_ready=0, and new operands not captured. Raise out_ready, then check in_ready=1 on the next cycle and that the second vector is processed correctly.
- Reset mid-RUN: assert rst on the 2nd RUN cycle. Check out_valid never pulses, the block returns to IDLE with result=0, and a subsequent vector yields correct results.
- SIGNED=1, LANES=4: element 0 = -128×127 → slot 0 = 0xC080; element 1 = -1×-1 → 0x0001; all other elements 0. Check dot = -16255 sign-extended to 19 bits.
